// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// hazard_fwd_unit: tracks EX/MEM/WB destinations and drives registered EX operand forward selects plus ID/EX stall/bubble.
// Optional feature macro HAZARD_FWD_EN: forwarding enabled; undefined builds an interlock-only controller.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [31:0]           stall_cnt
);

  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic                  ex_we, ex_ld, mem_we, wb_we;
  logic                  ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic                  hazard, load_ex;

  // x0 never matches, so it can neither forward nor stall.
  assign ex_hit_a  = id_use_rs1 & (id_rs1 != '0) & ex_we  & (ex_rd  == id_rs1);
  assign ex_hit_b  = id_use_rs2 & (id_rs2 != '0) & ex_we  & (ex_rd  == id_rs2);
  assign mem_hit_a = id_use_rs1 & (id_rs1 != '0) & mem_we & (mem_rd == id_rs1);
  assign mem_hit_b = id_use_rs2 & (id_rs2 != '0) & mem_we & (mem_rd == id_rs2);

`ifdef HAZARD_FWD_EN
  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  logic [SEL_W-1:0] sel_a_nxt, sel_b_nxt;

  assign hazard = ex_ld & (ex_hit_a | ex_hit_b);

  // An instruction now in EX will sit in MEM when the ID instruction reaches EX.
  always_comb begin
    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    if (load_ex) begin
      if (ex_hit_a)       sel_a_nxt = SEL_MEM;
      else if (mem_hit_a) sel_a_nxt = SEL_WB;
      if (ex_hit_b)       sel_b_nxt = SEL_MEM;
      else if (mem_hit_b) sel_b_nxt = SEL_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      fwd_a_sel <= sel_a_nxt;
      fwd_b_sel <= sel_b_nxt;
    end
  end
`else
  logic unused_ld;

  assign hazard    = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
  assign unused_ld = ex_ld;
`endif

  assign stall   = id_valid & hazard & ~ex_flush;
  assign bubble  = stall | ex_flush;
  assign load_ex = id_valid & ~stall & ~ex_flush;

  // WB slot is kept for visibility only; the register file's write-first read covers it.
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_we};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (load_ex) begin
        ex_rd <= id_rd;
        ex_we <= id_reg_write;
        ex_ld <= id_mem_read;
      end else begin
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
      end
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// tb_hazard_fwd_unit: directed instruction sequences; expectations queued by the driver, checked by a monitor.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, ex_flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, bubble;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_ADDR_W(5), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_flush(ex_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic        st;
    logic        bu;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, "stall",     {31'd0, stall},     {31'd0, e.st});
      chk(n, "bubble",    {31'd0, bubble},    {31'd0, e.bu});
      chk(n, "fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, e.a});
      chk(n, "fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, e.b});
      chk(n, "stall_cnt", stall_cnt,          e.cnt);
    end
  end

  // Present one ID-stage cycle and queue what the outputs must show during it.
  task automatic step(input string nm, input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic rw,
                      input logic ld, input logic fl, input logic rs,
                      input logic es, input logic eb, input logic [1:0] ea, input logic [1:0] ebs);
    exp_t e;
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = ld; ex_flush = fl; rst = rs;
    e.st = es; e.bu = eb; e.a = ea; e.b = ebs; e.cnt = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (rs) exp_cnt = '0;
    else if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input string nm, input logic [1:0] ea, input logic [1:0] ebs);
    step(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, ebs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit drained;
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; ex_flush = 1'b0; exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    nop("reset", 2'd0, 2'd0);

    // Back-to-back ALU dependency: add x5 ; sub x8, x5, x6
    step("b2b_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
`ifdef HAZARD_FWD_EN
    step("b2b_sub", 1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("b2b_ex", 2'd1, 2'd0);
`else
    step("b2b_sub_st1", 1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("b2b_sub_st2", 1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("b2b_sub_go",  1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("b2b_ex", 2'd0, 2'd0);
`endif
    nop("b2b_drain", 2'd0, 2'd0);

    // One-gap dependency: addi x7 ; nop ; or x11, x2, x7
    step("gap_addi", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("gap_nop", 2'd0, 2'd0);
`ifdef HAZARD_FWD_EN
    step("gap_or", 1, 5'd2, 1, 5'd7, 1, 5'd11, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("gap_ex", 2'd0, 2'd2);
`else
    step("gap_or_st", 1, 5'd2, 1, 5'd7, 1, 5'd11, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("gap_or_go", 1, 5'd2, 1, 5'd7, 1, 5'd11, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("gap_ex", 2'd0, 2'd0);
`endif
    nop("gap_drain", 2'd0, 2'd0);

    // Double match: two writers of x3, then a consumer of x3
    step("dbl_w1", 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    step("dbl_w2", 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
`ifdef HAZARD_FWD_EN
    step("dbl_use", 1, 5'd3, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("dbl_ex", 2'd1, 2'd0);
`else
    step("dbl_use_st1", 1, 5'd3, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("dbl_use_st2", 1, 5'd3, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("dbl_use_go",  1, 5'd3, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("dbl_ex", 2'd0, 2'd0);
`endif
    nop("dbl_drain", 2'd0, 2'd0);

    // Load-use: lw x9 ; add x13, x9, x4
    step("lu_lw", 1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("lu_add_st", 1, 5'd9, 1, 5'd4, 1, 5'd13, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
`ifdef HAZARD_FWD_EN
    step("lu_add_go", 1, 5'd9, 1, 5'd4, 1, 5'd13, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("lu_ex", 2'd2, 2'd0);
`else
    step("lu_add_st2", 1, 5'd9, 1, 5'd4, 1, 5'd13, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    step("lu_add_go",  1, 5'd9, 1, 5'd4, 1, 5'd13, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("lu_ex", 2'd0, 2'd0);
`endif
    nop("lu_drain", 2'd0, 2'd0);

    // Flush during hazard: addi x10 ; lw x9 ; add x14, x9, x10 with ex_flush
    step("fl_addi", 1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    step("fl_lw",   1, 5'd2, 1, 5'd0, 0, 5'd9,  1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("fl_add",  1, 5'd9, 1, 5'd10, 1, 5'd14, 1, 0, 1, 0, 0, 1, 2'd0, 2'd0);
    nop("fl_next",  2'd0, 2'd0);
    nop("fl_drain", 2'd0, 2'd0);

    // x0: lw x0 ; consumer of x0 on both sources
    step("x0_lw",  1, 5'd2, 1, 5'd0, 0, 5'd0,  1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("x0_use", 1, 5'd0, 1, 5'd0, 1, 5'd15, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("x0_ex",    2'd0, 2'd0);
    nop("x0_drain", 2'd0, 2'd0);

    // Reset asserted while a load-use stall is showing
    step("rst_lw",    1, 5'd2, 1, 5'd0, 0, 5'd9,  1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("rst_stall", 1, 5'd9, 1, 5'd0, 0, 5'd16, 1, 0, 0, 1, 1, 1, 2'd0, 2'd0);
    step("rst_after", 1, 5'd9, 1, 5'd0, 0, 5'd16, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("rst_idle", 2'd0, 2'd0);

    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!drained) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline hazard controller for the 5-stage RISC-V core. Tracks the destination register of the instructions in the EX, MEM and WB slots. From that state it produces registered forwarding select codes for the two EX-stage operand muxes: `mux_gen` instances with NUM_INPUTS=3 and DATA_WIDTH=32. It also produces the load-use stall and bubble signals for the ID/EX boundary. It sits directly upstream of the operand muxes and drives their `sel` inputs.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register index width.
- `SEL_W`, 2, forwarding select width; must equal $clog2(3).

Ports:
- `clk` input 1 — core clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `id_valid` input 1 — ID holds a real instruction.
- `id_rs1`, `id_rs2` input REG_ADDR_W — ID source indices.
- `id_use_rs1`, `id_use_rs2` input 1 — source actually read by the instruction.
- `id_rd` input REG_ADDR_W — ID destination index.
- `id_reg_write` input 1 — ID instruction writes rd.
- `id_mem_read` input 1 — ID instruction is a load.
- `ex_flush` input 1 — branch/jump redirect resolved in EX this cycle.
- `fwd_a_sel`, `fwd_b_sel` output SEL_W — select codes for operand A/B muxes, valid in EX.
- `stall` output 1 — hold PC and IF/ID, combinational.
- `bubble` output 1 — ID/EX register loads a NOP next edge.
- `stall_cnt` output 32 — saturating count of stall cycles.

## Operation
- Select codes: 0 = register-file operand, 1 = MEM-slot ALU result, 2 = WB-slot writeback data, 3 = never driven.
- Internal slots: EX{rd,we,ld}, MEM{rd,we}, WB{rd,we}. Each edge shifts EX→MEM→WB and loads the EX slot from ID.
- EX-slot load rule: the EX slot loads the ID values when `id_valid & ~stall & ~ex_flush`. Otherwise it loads a bubble (we=0, ld=0, rd=0).
- Forward decision per source s (rs1→A, rs2→B), evaluated in ID and registered into `fwd_*_sel`:
  - If `id_use_s`, s≠0, EX.we and EX.rd==s → 1.
  - Else if `id_use_s`, s≠0, MEM.we and MEM.rd==s → 2.
  - Otherwise → 0.
  - The EX-slot match has priority over the MEM-slot match.
- The select registers take 0 on any cycle where the EX slot receives a bubble.
- Load-use hazard: `stall = id_valid & EX.ld & EX.we & EX.rd≠0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)) & ~ex_flush`.
- Stall recovery: the following cycle re-evaluates with the load in the MEM slot, yielding sel=2.
- `bubble = stall | ex_flush`.
- `ex_flush` overrides a stall. When both hazard conditions hold, `stall`=0 and `bubble`=1.
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at 0xFFFF_FFFF.
- x0 is never forwarded and never causes a stall.

## Timing
- Reset: all slots are cleared to bubbles, `fwd_a_sel`=`fwd_b_sel`=0 and `stall_cnt`=0. `stall` and `bubble` are therefore 0 in the cycle after reset.
- A reset asserted mid-stall clears the condition; `stall` is 0 on the next cycle.
- Select latency: one cycle. The value computed while an instruction is in ID is presented while it is in EX, aligned with the operands from the ID/EX register.
- `stall` and `bubble` are combinational from the inputs and slot state, with zero latency.
- A load-use hazard costs exactly one stall cycle per load-use pair.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding is active as described above.
- `HAZARD_FWD_EN` undefined: interlock-only mode.
  - `fwd_a_sel` and `fwd_b_sel` are constant 0.
  - `stall` asserts for any used, nonzero source matching a writing EX slot or MEM slot, regardless of `ld`. `ex_flush` still overrides.
  - Dependent pairs cost 2 cycles when back-to-back and 1 cycle with a single gap. The register file's write-first read covers the WB slot.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: `add x5` in ID, then next cycle `sub` with rs1=x5 in ID.
  - Required: `fwd_a_sel`=1 while `sub` is in EX, `stall` never 1.
  - Without `HAZARD_FWD_EN`: `stall`=1 for 2 cycles.
- One-gap dependency:
  - Stimulus: `addi x7`, `nop`, `or` using rs2=x7.
  - Required: `fwd_b_sel`=2 with `or` in EX.
- Double match:
  - Stimulus: x3 written by two consecutive instructions, then a consumer of x3.
  - Required: `fwd_a_sel`=1, so the EX slot wins.
- Load-use:
  - Stimulus: `lw x9`, then `add` using rs1=x9.
  - Required: `stall`=1 and `bubble`=1 for one cycle, then `fwd_a_sel`=2; `stall_cnt` goes 0→1.
- Flush during hazard:
  - Stimulus: load-use condition and `ex_flush`=1 in the same cycle.
  - Required: `stall`=0, `bubble`=1, next-cycle sels 0, `stall_cnt` unchanged.
- x0 and reset:
  - Stimulus: `lw x0` followed by a consumer of x0.
  - Required: no stall, sel 0.
  - Stimulus: `rst` asserted during a stall.
  - Required: all outputs 0 the next cycle.
